// File: rtl/uart_rx_fifo_pkg.sv
// Register map, bit positions and address decode shared by the UART receive FIFO
// and the rest of the SoC.
package uart_rx_fifo_pkg;

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_BREAK     = 3;
  localparam int ST_COUNT_LSB = 8;

  localparam int CTRL_RX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_DATA,
    REG_STATUS,
    REG_CTRL
  } reg_sel_e;

  // Only the upper 28 bits select the window; unmapped offsets decode to nothing.
  function automatic reg_sel_e decode_reg(input logic [31:0] addr, input logic [31:0] base);
    reg_sel_e sel;
    sel = REG_NONE;
    if (addr[31:4] == base[31:4]) begin
      case (addr[3:0])
        OFF_DATA:   sel = REG_DATA;
        OFF_STATUS: sel = REG_STATUS;
        OFF_CTRL:   sel = REG_CTRL;
        default:    sel = REG_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head-of-queue output and a synchronous flush.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign count = count_reg;
  assign rdata = empty ? '0 : mem[rd_ptr_reg];

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Memory-mapped receive FIFO for a UART: DATA pops the head, STATUS reports fill
// level and sticky error flags, CTRL holds enables and the flush strobe.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          DEPTH     = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx_valid,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_break,
  output logic        uart_rx_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  input  logic        mem_re,
  output logic [31:0] mem_rdata,
  output logic        rx_irq
);

  reg_sel_e    reg_sel;
  logic        status_wr;
  logic        ctrl_wr;
  logic        re_match;
  logic        re_prev_reg;
  logic        pop_req;
  logic        push_req;
  logic        flush;
  logic        overflow_set;
  logic        overflow_reg;
  logic        break_reg;
  logic        rx_en_reg;
  logic        irq_en_reg;
  logic        rx_irq_reg;
  logic [7:0]  head_byte;
  logic [AW:0] fifo_count;
  logic        fifo_full;
  logic        fifo_empty;
  logic        unused_wdata;

  assign reg_sel   = decode_reg(mem_addr, BASE_ADDR);
  assign status_wr = mem_we & (reg_sel == REG_STATUS);
  assign ctrl_wr   = mem_we & (reg_sel == REG_CTRL);

  // The core may hold mem_re for several cycles; only the rising edge pops.
  assign re_match = mem_re & (reg_sel == REG_DATA);
  assign pop_req  = re_match & ~re_prev_reg;

  assign push_req     = uart_rx_valid & ~uart_rx_break;
  assign flush        = ctrl_wr & mem_wdata[CTRL_FLUSH];
  assign overflow_set = push_req & fifo_full & ~pop_req;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push_req),
    .pop   (pop_req),
    .wdata (uart_rx_data),
    .rdata (head_byte),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_prev_reg  <= 1'b0;
      overflow_reg <= 1'b0;
      break_reg    <= 1'b0;
      rx_en_reg    <= 1'b1;
      irq_en_reg   <= 1'b0;
      rx_irq_reg   <= 1'b0;
    end else begin
      re_prev_reg <= re_match;
      // Set events take priority over a same-cycle write-one-to-clear.
      overflow_reg <= overflow_set |
                      (overflow_reg & ~(status_wr & mem_wdata[ST_OVERFLOW]));
      break_reg    <= uart_rx_break |
                      (break_reg & ~(status_wr & mem_wdata[ST_BREAK]));
      if (ctrl_wr) begin
        rx_en_reg  <= mem_wdata[CTRL_RX_EN];
        irq_en_reg <= mem_wdata[CTRL_IRQ_EN];
      end
      rx_irq_reg <= irq_en_reg & (~fifo_empty | overflow_reg | break_reg);
    end
  end

  always_comb begin
    mem_rdata = '0;
    case (reg_sel)
      REG_DATA: mem_rdata = {24'b0, head_byte};
      REG_STATUS: begin
        mem_rdata[ST_COUNT_LSB +: 8] = 8'(fifo_count);
        mem_rdata[ST_BREAK]          = break_reg;
        mem_rdata[ST_OVERFLOW]       = overflow_reg;
        mem_rdata[ST_FULL]           = fifo_full;
        mem_rdata[ST_NOT_EMPTY]      = ~fifo_empty;
      end
      REG_CTRL: begin
        mem_rdata[CTRL_IRQ_EN] = irq_en_reg;
        mem_rdata[CTRL_RX_EN]  = rx_en_reg;
      end
      default: mem_rdata = '0;
    endcase
  end

  assign uart_rx_en   = rx_en_reg;
  assign rx_irq       = rx_irq_reg;
  assign unused_wdata = ^mem_wdata[31:4];

endmodule
